// File: rtl/credit_pkg.sv
// rtl/credit_pkg.sv - credit-link shared parameters, types and width check
`ifndef CREDIT_PKG_SV
`define CREDIT_PKG_SV

// Pending credits reach DEPTH, so the counter needs one bit more than the pointers.
`define CREDIT_WIDTH_CHECK(cw, aw) \
  if ((cw) < (aw) + 1) begin : g_credit_width_check \
    $error("CREDIT_WIDTH must be at least A_WIDTH+1"); \
  end

package credit_pkg;

  localparam int LINK_A_WIDTH = 2;

  function automatic int depth(input int a_width);
    return 1 << a_width;
  endfunction

  localparam int LINK_DEPTH = depth(LINK_A_WIDTH);

  typedef logic [LINK_A_WIDTH-1:0] ptr_t;
  typedef logic [LINK_A_WIDTH:0]   count_t;

endpackage

`endif

// File: rtl/credit_fifo_mem.sv
// rtl/credit_fifo_mem.sv - DEPTH x D_WIDTH register array, one write and one read port
module credit_fifo_mem
  import credit_pkg::*;
#(
  parameter int D_WIDTH = 6,
  parameter int A_WIDTH = 2
) (
  input  logic               clk,
  input  logic               we,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [A_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem [depth(A_WIDTH)];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/credit_rx_buffer.sv
// rtl/credit_rx_buffer.sv - credited receive FIFO with stallable credit-return channel
module credit_rx_buffer
  import credit_pkg::*;
#(
  parameter int D_WIDTH      = 6,
  parameter int A_WIDTH      = 2,
  parameter int CREDIT_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid,
  input  logic [D_WIDTH-1:0] up_data,
  output logic               down_valid,
  input  logic               down_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               credit_valid,
  input  logic               credit_ready,
  output logic               overflow
);

  localparam int               DEPTH      = depth(A_WIDTH);
  localparam logic [A_WIDTH:0] FULL_COUNT = (A_WIDTH+1)'(DEPTH);

  `CREDIT_WIDTH_CHECK(CREDIT_WIDTH, A_WIDTH)

  logic [A_WIDTH-1:0]      wr_ptr;
  logic [A_WIDTH-1:0]      rd_ptr;
  logic [A_WIDTH:0]        count;
  logic [CREDIT_WIDTH-1:0] pending;
  logic                    push;
  logic                    pop;
  logic                    ret;
  logic                    full;
  logic                    accept;

  assign push         = up_valid;
  assign full         = (count == FULL_COUNT);
  assign down_valid   = (count != '0);
  assign pop          = down_valid & down_ready;
  assign accept       = push & (~full | pop);
  assign credit_valid = (pending != '0);
  assign ret          = credit_valid & credit_ready;

  credit_fifo_mem #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (up_data),
    .raddr (rd_ptr),
    .rdata (down_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept && !pop) begin
        count <= count + 1'b1;
      end else if (!accept && pop) begin
        count <= count - 1'b1;
      end
      if (pop && !ret) begin
        pending <= pending + 1'b1;
      end else if (!pop && ret) begin
        pending <= pending - 1'b1;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // A push at full is tolerated when it pairs with a pop, but such a sender has
  // overspent its credits; the occupancy bound only holds for a sender that never did.
  logic credit_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_overrun <= 1'b0;
    end else if (push && full) begin
      credit_overrun <= 1'b1;
    end
  end

  a_overflow_flag: assert property (@(posedge clk) disable iff (rst)
    (push && full && !pop) |=> overflow);

  a_pending_bound: assert property (@(posedge clk) disable iff (rst)
    int'(pending) <= DEPTH);

  a_occupancy: assert property (@(posedge clk) disable iff (rst || credit_overrun)
    int'(count) + int'(pending) <= DEPTH);

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (down_valid && !down_ready) |=> $stable(down_data));

endmodule

// File: tb/tb_credit_rx_buffer.sv
// tb/tb_credit_rx_buffer.sv - scoreboard bench for credit_rx_buffer
module tb_credit_rx_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid;
  logic [5:0] up_data;
  logic       down_valid;
  logic       down_ready;
  logic [5:0] down_data;
  logic       credit_valid;
  logic       credit_ready;
  logic       overflow;

  int         checks  = 0;
  int         errors  = 0;
  int         ret_cnt = 0;
  int         r0;
  logic [5:0] exp_q[$];

  credit_rx_buffer #(
    .D_WIDTH      (6),
    .A_WIDTH      (2),
    .CREDIT_WIDTH (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .up_valid     (up_valid),
    .up_data      (up_data),
    .down_valid   (down_valid),
    .down_ready   (down_ready),
    .down_data    (down_data),
    .credit_valid (credit_valid),
    .credit_ready (credit_ready),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [5:0] d, input bool_exp);
    up_valid = 1'b1;
    up_data  = d;
    if (bool_exp) exp_q.push_back(d);
    tick();
    up_valid = 1'b0;
  endtask

  // Monitor: every accepted downstream word must be the next scoreboard entry.
  always @(negedge clk) begin
    logic [5:0] exp;
    if (!rst) begin
      if (down_valid && down_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %0h, required no word", down_data);
        end else begin
          exp = exp_q.pop_front();
          if (down_data !== exp) begin
            errors++;
            $display("FAIL pop_data: got %0h, required %0h", down_data, exp);
          end
        end
      end
      if (credit_valid && credit_ready) ret_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] cv_exp;
    logic [5:0] dv_exp;
    cv_exp = 6'b011110;
    dv_exp = 6'b001111;

    rst = 1'b1; up_valid = 1'b0; up_data = '0; down_ready = 1'b0; credit_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    sample();
    chk("reset_down_valid", down_valid, 0);
    chk("reset_credit_valid", credit_valid, 0);
    chk("reset_overflow", overflow, 0);
    tick();

    // 1: fill while stalled
    for (int i = 1; i <= 4; i++) push_word(6'(i), 1);
    sample();
    chk("t1_count", int'(dut.count), 4);
    chk("t1_down_valid", down_valid, 1);
    chk("t1_down_data", down_data, 6'h01);
    chk("t1_credit_valid", credit_valid, 0);
    tick();

    // 2: drain with credits accepted
    r0 = ret_cnt;
    down_ready = 1'b1; credit_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk($sformatf("t2_credit_valid_c%0d", i), credit_valid, int'(cv_exp[i]));
      chk($sformatf("t2_down_valid_c%0d", i), down_valid, int'(dv_exp[i]));
      tick();
    end
    chk("t2_credits_returned", ret_cnt - r0, 4);
    sample();
    chk("t2_count", int'(dut.count), 0);
    chk("t2_pending", int'(dut.pending), 0);
    tick();

    // 3: drain with credit return stalled
    down_ready = 1'b0; credit_ready = 1'b0;
    for (int i = 5; i <= 8; i++) push_word(6'(i), 1);
    r0 = ret_cnt;
    down_ready = 1'b1;
    repeat (4) tick();
    down_ready = 1'b0;
    sample();
    chk("t3_pending", int'(dut.pending), 4);
    chk("t3_credit_valid", credit_valid, 1);
    chk("t3_down_valid", down_valid, 0);
    repeat (3) tick();
    sample();
    chk("t3_credit_held", credit_valid, 1);
    tick();
    chk("t3_no_ret_stalled", ret_cnt - r0, 0);
    credit_ready = 1'b1;
    repeat (4) tick();
    credit_ready = 1'b0;
    chk("t3_credits_returned", ret_cnt - r0, 4);
    sample();
    chk("t3_credit_valid_end", credit_valid, 0);
    tick();

    // 4: push and pop together while full
    for (int i = 0; i < 4; i++) push_word(6'h10 + 6'(i), 1);
    up_valid = 1'b1; up_data = 6'h2A; down_ready = 1'b1;
    exp_q.push_back(6'h2A);
    tick();
    up_valid = 1'b0; down_ready = 1'b0;
    sample();
    chk("t4_count", int'(dut.count), 4);
    chk("t4_overflow", overflow, 0);
    chk("t4_head", down_data, 6'h11);
    tick();
    credit_ready = 1'b1; down_ready = 1'b1;
    repeat (6) tick();
    down_ready = 1'b0;
    repeat (2) tick();
    sample();
    chk("t4_drained", down_valid, 0);
    chk("t4_overflow_end", overflow, 0);
    chk("t4_credit_valid_end", credit_valid, 0);
    tick();

    // 5: push while full and stalled is dropped
    for (int i = 0; i < 4; i++) push_word(6'h20 + 6'(i), 1);
    push_word(6'h3F, 0);
    sample();
    chk("t5_overflow", overflow, 1);
    chk("t5_count", int'(dut.count), 4);
    chk("t5_head", down_data, 6'h20);
    repeat (3) tick();
    sample();
    chk("t5_overflow_sticky", overflow, 1);
    tick();
    down_ready = 1'b1;
    repeat (5) tick();
    down_ready = 1'b0;
    sample();
    chk("t5_drained", down_valid, 0);
    chk("t5_overflow_after_drain", overflow, 1);
    tick();

    // 6: pointer wrap, then reset mid-stream
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    sample();
    chk("t6_overflow_cleared", overflow, 0);
    tick();
    down_ready = 1'b1; credit_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_word(6'h30 + 6'(i), 1);
    repeat (3) tick();
    sample();
    chk("t6_wrap_drained", down_valid, 0);
    chk("t6_wrap_queue", exp_q.size(), 0);
    chk("t6_wrap_pending", int'(dut.pending), 0);
    tick();
    down_ready = 1'b0; credit_ready = 1'b0;
    push_word(6'h01, 1);
    push_word(6'h02, 1);
    down_ready = 1'b1;
    tick();
    down_ready = 1'b0;
    sample();
    chk("t6_pre_rst_down_valid", down_valid, 1);
    chk("t6_pre_rst_credit_valid", credit_valid, 1);
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    sample();
    chk("t6_rst_down_valid", down_valid, 0);
    chk("t6_rst_credit_valid", credit_valid, 0);
    chk("t6_rst_overflow", overflow, 0);
    tick();
    rst = 1'b0;
    tick();
    sample();
    chk("t6_post_rst_down_valid", down_valid, 0);
    chk("t6_post_rst_credit_valid", credit_valid, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
